pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for a simple fetch/execute core. It walks
// IDLE -> FETCH -> EXEC -> FETCH ... and updates the PC once per retired
// instruction. Each instruction ends with a sequential step or a
// register/label/conditional transfer. It stops in HALT on a halt request,
// a fetch timeout or a misaligned target, and only reset leaves HALT.
//
// Handshakes:
//   o_imem_req is held high for the whole FETCH state. The fetch completes on
//   the first cycle in FETCH where i_imem_ack is high. i_imem_ack is ignored in
//   every other state. In EXEC, i_ex_done marks the end of the instruction,
//   and the branch inputs are sampled only in that cycle. i_ex_done is
//   ignored in every other state.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               leave IDLE and begin fetching
//   i_halt_req            sticky stop request, honoured at an instruction boundary
//   o_imem_req/o_imem_addr fetch request and address (always equal to o_pc)
//   i_imem_ack            fetch complete
//   i_ex_done             current instruction finished, branch inputs valid
//   i_br_*                branch/jump controls and operands
//   o_pc                  current program counter
//   o_redirect            one-cycle pulse when a taken transfer loaded o_pc
//   o_instr_count         retired-instruction counter (wrapping)
//   o_busy                high in FETCH or EXEC
//   o_state               IDLE=0, FETCH=1, EXEC=2, HALT=3
//   o_mem_err/o_align_err sticky error flags
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_halt_req,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic        i_ex_done,
    input  logic        i_br_valid,
    input  logic        i_br_cond,
    input  logic        i_br_lbl_sel,
    input  logic        i_br_reg_sel,
    input  logic [25:0] i_br_off26,
    input  logic [15:0] i_br_off16,
    input  logic [31:0] i_br_reg_addr,
    output logic [31:0] o_pc,
    output logic        o_redirect,
    output logic [31:0] o_instr_count,
    output logic        o_busy,
    output logic [2:0]  o_state,
    output logic        o_mem_err,
    output logic        o_align_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3
    } state_t;

    // The wait counter holds the number of FETCH cycles already spent.
    // The timeout fires in the TIMEOUT-th FETCH cycle, when the count is
    // TIMEOUT-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr_count;
    logic [15:0] r_wait;
    logic        r_halt_lat;
    logic        r_imem_req;
    logic        r_busy;
    logic        r_redirect;
    logic        r_mem_err;
    logic        r_align_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_misalign;
    logic        w_halt;

    // Next-PC selection. The priority order is register jump, then label
    // jump, then taken conditional branch, then sequential.
    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        w_target   = w_pc_plus4;
        w_taken    = 1'b0;
        if (i_br_reg_sel) begin
            w_target = i_br_reg_addr;
            w_taken  = 1'b1;
        end else if (i_br_lbl_sel) begin
            w_target = w_pc_plus4 + {{6{i_br_off26[25]}}, i_br_off26};
            w_taken  = 1'b1;
        end else if (i_br_valid && i_br_cond) begin
            w_target = w_pc_plus4 + {{16{i_br_off16[15]}}, i_br_off16};
            w_taken  = 1'b1;
        end
        w_misalign = (w_target[1:0] != 2'b00);
        // A request arriving this cycle counts as already latched.
        w_halt     = r_halt_lat | i_halt_req;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr_count <= 32'd0;
            r_wait        <= 16'd0;
            r_halt_lat    <= 1'b0;
            r_imem_req    <= 1'b0;
            r_busy        <= 1'b0;
            r_redirect    <= 1'b0;
            r_mem_err     <= 1'b0;
            r_align_err   <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            r_halt_lat <= w_halt;
            case (r_state)
                S_IDLE: begin
                    if (w_halt) begin
                        r_state <= S_HALT;
                    end else if (i_start) begin
                        r_state    <= S_FETCH;
                        r_wait     <= 16'd0;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // An acknowledge in the timeout cycle still wins.
                    if (i_imem_ack) begin
                        r_state    <= S_EXEC;
                        r_imem_req <= 1'b0;
                    end else if (r_wait >= WAIT_LAST) begin
                        r_state    <= S_HALT;
                        r_mem_err  <= 1'b1;
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (i_ex_done) begin
                        if (w_misalign) begin
                            // The PC and the counter are left untouched.
                            r_state     <= S_HALT;
                            r_align_err <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_pc          <= w_target;
                            r_instr_count <= r_instr_count + 32'd1;
                            r_redirect    <= w_taken;
                            if (w_halt) begin
                                r_state <= S_HALT;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state    <= S_FETCH;
                                r_wait     <= 16'd0;
                                r_imem_req <= 1'b1;
                            end
                        end
                    end
                end
                S_HALT: begin
                    r_imem_req <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_redirect    = r_redirect;
    assign o_instr_count = r_instr_count;
    assign o_busy        = r_busy;
    assign o_state       = r_state;
    assign o_mem_err     = r_mem_err;
    assign o_align_err   = r_align_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer with the default parameters
// (RESET_PC = 0, TIMEOUT = 15). Inputs change on the falling edge and outputs
// are sampled on the falling edge, half a cycle after the rising edge that
// updated them. Each scenario task checks its own results inline.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        ex_done;
    logic        br_valid;
    logic        br_cond;
    logic        br_lbl_sel;
    logic        br_reg_sel;
    logic [25:0] br_off26;
    logic [15:0] br_off16;
    logic [31:0] br_reg_addr;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] instr_count;
    logic        busy;
    logic [2:0]  state;
    logic        mem_err;
    logic        align_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_halt_req   (halt_req),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_ex_done    (ex_done),
        .i_br_valid   (br_valid),
        .i_br_cond    (br_cond),
        .i_br_lbl_sel (br_lbl_sel),
        .i_br_reg_sel (br_reg_sel),
        .i_br_off26   (br_off26),
        .i_br_off16   (br_off16),
        .i_br_reg_addr(br_reg_addr),
        .o_pc         (pc),
        .o_redirect   (redirect),
        .o_instr_count(instr_count),
        .o_busy       (busy),
        .o_state      (state),
        .o_mem_err    (mem_err),
        .o_align_err  (align_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_br();
        br_valid    = 1'b0;
        br_cond     = 1'b0;
        br_lbl_sel  = 1'b0;
        br_reg_sel  = 1'b0;
        br_off26    = 26'd0;
        br_off16    = 16'd0;
        br_reg_addr = 32'd0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; halt_req = 1'b0;
        imem_ack = 1'b0; ex_done = 1'b0;
        clear_br();
        step();
        rst = 1'b0;
    endtask

    // Enters FETCH from IDLE.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called while in FETCH: idle for 'waits' cycles, then acknowledge.
    task automatic fetch_ack(input int waits);
        for (int i = 0; i < waits; i++) step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
    endtask

    // Called while in EXEC: present the branch inputs with ex_done for one edge.
    task automatic exec(input logic rs, input logic ls, input logic bv, input logic bc,
                        input logic [31:0] raddr, input logic [25:0] o26,
                        input logic [15:0] o16);
        br_reg_sel = rs; br_lbl_sel = ls; br_valid = bv; br_cond = bc;
        br_reg_addr = raddr; br_off26 = o26; br_off16 = o16;
        ex_done = 1'b1;
        step();
        ex_done = 1'b0;
        clear_br();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (state !== 3'd0 || pc !== 32'h0 || instr_count !== 32'd0 || imem_req !== 1'b0 ||
            busy !== 1'b0 || redirect !== 1'b0 || mem_err !== 1'b0 || align_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d pc=%h cnt=%0d req=%b busy=%b rd=%b me=%b ae=%b expected 0/0/0/0/0/0/0/0",
                     state, pc, instr_count, imem_req, busy, redirect, mem_err, align_err);
        end
        step();
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got state %0d expected 0", state);
        end
    endtask

    task automatic test_sequential();
        do_start();
        n_checks++;
        if (state !== 3'd1 || imem_req !== 1'b1 || busy !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL seq_fetch: got st=%0d req=%b busy=%b addr=%h expected 1/1/1/0",
                     state, imem_req, busy, imem_addr);
        end
        // An ex_done that arrives in FETCH must be ignored.
        ex_done = 1'b1;
        step();
        ex_done = 1'b0;
        n_checks++;
        if (pc !== 32'h0 || instr_count !== 32'd0 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL seq_exdone_ignored: got pc=%h cnt=%0d st=%0d expected 0/0/1", pc, instr_count, state);
        end
        fetch_ack(1);
        n_checks++;
        if (state !== 3'd2 || imem_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_exec: got st=%0d req=%b busy=%b expected 2/0/1", state, imem_req, busy);
        end
        // An imem_ack that arrives in EXEC must be ignored.
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL seq_ack_ignored: got state %0d expected 2", state);
        end
        exec(0, 0, 0, 0, 32'h0, 26'h0, 16'h0);
        n_checks++;
        if (pc !== 32'h4 || instr_count !== 32'd1 || redirect !== 1'b0 || state !== 3'd1 ||
            imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL seq_retire: got pc=%h cnt=%0d rd=%b st=%0d expected 4/1/0/1",
                     pc, instr_count, redirect, state);
        end
    endtask

    task automatic test_branch();
        // Register jump from 0x4 to 0x100.
        fetch_ack(0);
        exec(1, 0, 0, 0, 32'h100, 26'h0, 16'h0);
        n_checks++;
        if (pc !== 32'h100 || redirect !== 1'b1 || instr_count !== 32'd2) begin
            n_fail++;
            $display("FAIL br_reg_jump: got pc=%h rd=%b cnt=%0d expected 100/1/2", pc, redirect, instr_count);
        end
        // Taken branch: 0x100 + 4 - 16 = 0xF4.
        fetch_ack(0);
        exec(0, 0, 1, 1, 32'h0, 26'h0, 16'hFFF0);
        n_checks++;
        if (pc !== 32'h0F4 || redirect !== 1'b1) begin
            n_fail++;
            $display("FAIL br_taken: got pc=%h rd=%b expected 0f4/1", pc, redirect);
        end
        step();
        n_checks++;
        if (redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL br_pulse_width: got redirect %b expected 0", redirect);
        end
        // Back to 0x100, then a not-taken branch falls through to 0x104.
        fetch_ack(0);
        exec(1, 0, 0, 0, 32'h100, 26'h0, 16'h0);
        fetch_ack(0);
        exec(0, 0, 1, 0, 32'h0, 26'h0, 16'hFFF0);
        n_checks++;
        if (pc !== 32'h104 || redirect !== 1'b0 || instr_count !== 32'd5) begin
            n_fail++;
            $display("FAIL br_not_taken: got pc=%h rd=%b cnt=%0d expected 104/0/5", pc, redirect, instr_count);
        end
        // Label jump with offset -4: 0x104 + 4 - 4 = 0x104.
        fetch_ack(2);
        exec(0, 1, 0, 0, 32'h0, 26'h3FF_FFFC, 16'h0);
        n_checks++;
        if (pc !== 32'h104 || redirect !== 1'b1 || instr_count !== 32'd6) begin
            n_fail++;
            $display("FAIL br_label: got pc=%h rd=%b cnt=%0d expected 104/1/6", pc, redirect, instr_count);
        end
    endtask

    task automatic test_priority();
        // A register jump outranks a label jump.
        fetch_ack(0);
        exec(1, 1, 1, 1, 32'h2000, 26'h100, 16'h40);
        n_checks++;
        if (pc !== 32'h2000 || instr_count !== 32'd7) begin
            n_fail++;
            $display("FAIL prio_reg_first: got pc=%h cnt=%0d expected 2000/7", pc, instr_count);
        end
        // A misaligned target halts and leaves the PC alone.
        fetch_ack(0);
        exec(1, 1, 0, 0, 32'h2002, 26'h0, 16'h0);
        n_checks++;
        if (align_err !== 1'b1 || pc !== 32'h2000 || state !== 3'd3 || instr_count !== 32'd7 ||
            redirect !== 1'b0 || busy !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_misalign: got ae=%b pc=%h st=%0d cnt=%0d rd=%b busy=%b req=%b expected 1/2000/3/7/0/0/0",
                     align_err, pc, state, instr_count, redirect, busy, imem_req);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        do_start();
        for (int i = 0; i < 14; i++) step();
        n_checks++;
        if (state !== 3'd1 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_still_fetch: got st=%0d me=%b expected 1/0", state, mem_err);
        end
        step();
        n_checks++;
        if (state !== 3'd3 || mem_err !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL to_expire: got st=%0d me=%b busy=%b req=%b expected 3/1/0/0",
                     state, mem_err, busy, imem_req);
        end
        // An acknowledge in the 15th FETCH cycle must still win.
        apply_reset();
        do_start();
        fetch_ack(14);
        n_checks++;
        if (state !== 3'd2 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_ack_wins: got st=%0d me=%b expected 2/0", state, mem_err);
        end
        // The wait counter clears on the next FETCH entry and the full budget is available again.
        exec(0, 0, 0, 0, 32'h0, 26'h0, 16'h0);
        fetch_ack(14);
        n_checks++;
        if (state !== 3'd2 || mem_err !== 1'b0 || pc !== 32'h4) begin
            n_fail++;
            $display("FAIL to_counter_clear: got st=%0d me=%b pc=%h expected 2/0/4", state, mem_err, pc);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        do_start();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        fetch_ack(1);
        n_checks++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL halt_completes: got state %0d expected 2", state);
        end
        exec(0, 0, 0, 0, 32'h0, 26'h0, 16'h0);
        n_checks++;
        if (state !== 3'd3 || pc !== 32'h4 || instr_count !== 32'd1 || busy !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_enter: got st=%0d pc=%h cnt=%0d busy=%b req=%b expected 3/4/1/0/0",
                     state, pc, instr_count, busy, imem_req);
        end
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        n_checks++;
        if (state !== 3'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_sticky: got st=%0d busy=%b expected 3/0", state, busy);
        end
        // A start and a halt_req together in IDLE go to HALT.
        apply_reset();
        start = 1'b1; halt_req = 1'b1;
        step();
        start = 1'b0; halt_req = 1'b0;
        step();
        n_checks++;
        if (state !== 3'd3 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_idle_start: got st=%0d req=%b expected 3/0", state, imem_req);
        end
    endtask

    task automatic test_reset_in_exec();
        apply_reset();
        do_start();
        fetch_ack(0);
        exec(1, 0, 0, 0, 32'h40, 26'h0, 16'h0);
        fetch_ack(0);
        n_checks++;
        if (state !== 3'd2 || pc !== 32'h40) begin
            n_fail++;
            $display("FAIL rst_setup: got st=%0d pc=%h expected 2/40", state, pc);
        end
        rst = 1'b1; ex_done = 1'b1;
        step();
        rst = 1'b0; ex_done = 1'b0;
        n_checks++;
        if (state !== 3'd0 || pc !== 32'h0 || instr_count !== 32'd0 || imem_req !== 1'b0 ||
            busy !== 1'b0 || redirect !== 1'b0 || mem_err !== 1'b0 || align_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_exec: got st=%0d pc=%h cnt=%0d req=%b busy=%b rd=%b me=%b ae=%b expected 0/0/0/0/0/0/0/0",
                     state, pc, instr_count, imem_req, busy, redirect, mem_err, align_err);
        end
        // The halt latch must be clear after reset, so a start proceeds.
        do_start();
        n_checks++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL rst_latch_clear: got state %0d expected 1", state);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0;
        imem_ack = 1'b0; ex_done = 1'b0;
        clear_br();
        step();
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_timeout();
        test_halt();
        test_reset_in_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
